ece453_button_conditioner: RTL and testbench
============================================

# ece453_button_conditioner

Upstream input stage for `ece453_fsm_example`: takes the raw push-button and direction switch from the board pins and produces the clean `button` and `direction` inputs that the LED FSM consumes. It performs two-flop synchronisation, counter-based debounce, and single-cycle press-pulse generation, with the direction sampled coherently alongside each pulse. An accepted-press counter is kept for software and bench observation, and auto-repeat can optionally be compiled in.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive synchronised-stable cycles required to accept a level change; legal range ≥1.
- `REPEAT_DELAY`, 16: cycles from the initial press pulse to the first repeat pulse; used only with repeat enabled.
- `REPEAT_PERIOD`, 8: cycles between subsequent repeat pulses; ≥1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the `clk` rising edge.
- `button_raw`  in  1  asynchronous push-button, active-high, bouncy.
- `dir_raw`  in  1  asynchronous direction switch level.
- `button_pulse`  out  1  one-cycle pulse per accepted press (and per repeat); drives FSM `button`.
- `direction`  out  1  synchronised `dir_raw`, updated only in `button_pulse` cycles; drives FSM `direction`.
- `button_level`  out  1  debounced button level.
- `press_count`  out  8  count of accepted initial presses; repeats are not counted.

## Operation
- Synchroniser: `button_raw` → s1 → s2, and `dir_raw` → d1 → d2, each a two-flop chain. All logic below uses s2/d2 only.
- FSM states: IDLE, DEB_PRESS, PRESSED, DEB_RELEASE. `cnt` is the debounce counter, width $clog2(DEBOUNCE_CYCLES+1).
- IDLE:
  - s2=1 → DEB_PRESS, with cnt=1.
- DEB_PRESS:
  - s2=0 → IDLE, with cnt=0 (bounce rejected, no pulse).
  - s2=1 and cnt==DEBOUNCE_CYCLES → PRESSED. On the same edge, register `button_pulse`=1, `direction`=d2, and `press_count`+1.
  - Otherwise cnt+1.
- PRESSED:
  - s2=0 → DEB_RELEASE, with cnt=1.
- DEB_RELEASE:
  - s2=1 → PRESSED (release bounce rejected, no pulse).
  - s2=0 and cnt==DEBOUNCE_CYCLES → IDLE.
  - Otherwise cnt+1.
  - No pulse is ever generated on release.
- `button_level` = 1 in PRESSED and DEB_RELEASE, 0 otherwise. It is registered alongside the state.
- `press_count` wraps 255→0 silently.
- `direction` holds its value between pulses, so the FSM always sees the direction captured with its pulse. Toggling `dir_raw` with no press does not change `direction`.

## Timing
- Reset (reset=0 at an edge): state IDLE; cnt, hold counter and all sync flops 0; `button_pulse`=0, `direction`=0, `button_level`=0, `press_count`=0. Reset asserted mid-debounce or mid-press aborts with no pulse.
- If `button_raw` is held high through reset release, it is treated as a fresh press and pulses after the normal latency.
- Press latency: let edge k be the first edge sampling `button_raw`=1, with the input stable thereafter. `button_pulse` is high for exactly one cycle after edge k+DEBOUNCE_CYCLES+2.
- `direction` reflects `dir_raw` as sampled at edge k+DEBOUNCE_CYCLES.
- Release latency: `button_level` falls after edge j+DEBOUNCE_CYCLES+2, where j is the first edge sampling `button_raw`=0.
- `button_pulse` is never high for two consecutive cycles.

## Configuration
- `ECE453_BTN_REPEAT_EN` defined: a hold counter clears on the PRESSED entry edge and increments every cycle in PRESSED. It is frozen during DEB_RELEASE and resumes if the FSM returns to PRESSED.
  - Repeat pulses occur REPEAT_DELAY cycles after the initial pulse, then every REPEAT_PERIOD cycles.
  - Each repeat pulse also recaptures `direction`=d2.
  - `press_count` is unchanged by repeats.
- Undefined: no hold counter and exactly one pulse per press regardless of hold time. The repeat parameters are ignored.

## Test plan
- Reset held low 3 cycles, then raw inputs 0 for 10 cycles → all outputs 0, `press_count`=0.
- DEBOUNCE_CYCLES=4, `button_raw` rises before edge k and is held 20 cycles with `dir_raw`=1 → single `button_pulse` after edge k+6, `direction`=1, `press_count`=1, `button_level`=1 until release+6.
- Bounce: `button_raw` high 2 cycles, low 1, high 2, then low → no pulse, `press_count`=0, `button_level` stays 0.
- Release bounce: after an accepted press, low 2 cycles, high 1, low 10 → no additional pulse; `button_level` falls 6 cycles after the final low sample.
- Reset asserted for 1 cycle after edge k+4 of a press → no pulse, `press_count`=0. With `button_raw` still high, a pulse follows 6 edges after the first post-reset sample.
- With `ECE453_BTN_REPEAT_EN`, hold 40 cycles past the initial pulse and toggle `dir_raw` at cycle 20 → repeat pulses at +16, +24, +32, +40 cycles; `direction` changes only at the +24 pulse; `press_count`=1. Without the macro → one pulse only.

Source files
------------

// File: rtl/ece453_button_conditioner.sv
// Button front end for ece453_fsm_example: two-flop sync, counter debounce, one-cycle press pulse.
// Optional feature macro: ECE453_BTN_REPEAT_EN compiles in hold-to-repeat pulses.
module ece453_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button_raw,
    input  logic       dir_raw,
    output logic       button_pulse,
    output logic       direction,
    output logic       button_level,
    output logic [7:0] press_count
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("ece453_button_conditioner: cycle parameters must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_RELEASE} state_t;

    state_t        state, state_next;
    logic          s1, s2, d1, d2;
    logic [CW-1:0] cnt, cnt_next;
    logic          pulse_next, dir_next, level_next;
    logic [7:0]    count_next;

`ifdef ECE453_BTN_REPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam logic [HW-1:0] FIRST_HIT = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] NEXT_HIT  = HW'(REPEAT_PERIOD - 1);

    logic [HW-1:0] hold, hold_next;
    logic          repeating, repeating_next;
    logic          rep_hit;

    // The first repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD; hold restarts at each pulse.
    assign rep_hit = (hold == (repeating ? NEXT_HIT : FIRST_HIT));
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            d1 <= 1'b0;
            d2 <= 1'b0;
        end else begin
            s1 <= button_raw;
            s2 <= s1;
            d1 <= dir_raw;
            d2 <= d1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            button_pulse <= 1'b0;
            direction    <= 1'b0;
            button_level <= 1'b0;
            press_count  <= '0;
`ifdef ECE453_BTN_REPEAT_EN
            hold         <= '0;
            repeating    <= 1'b0;
`endif
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            button_pulse <= pulse_next;
            direction    <= dir_next;
            button_level <= level_next;
            press_count  <= count_next;
`ifdef ECE453_BTN_REPEAT_EN
            hold         <= hold_next;
            repeating    <= repeating_next;
`endif
        end
    end

    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latch).
        state_next     = state;
        cnt_next       = cnt;
        pulse_next     = 1'b0;
        dir_next       = direction;
        count_next     = press_count;
`ifdef ECE453_BTN_REPEAT_EN
        hold_next      = hold;
        repeating_next = repeating;
`endif
        unique case (state)
            IDLE: begin
                if (s2) begin
                    state_next = DEB_PRESS;
                    cnt_next   = CW'(1);
                end
            end
            DEB_PRESS: begin
                if (!s2) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_DONE) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                    pulse_next = 1'b1;
                    dir_next   = d2;
                    count_next = press_count + 8'd1;
`ifdef ECE453_BTN_REPEAT_EN
                    hold_next      = '0;
                    repeating_next = 1'b0;
`endif
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            PRESSED: begin
                if (!s2) begin
                    state_next = DEB_RELEASE;
                    cnt_next   = CW'(1);
                end
`ifdef ECE453_BTN_REPEAT_EN
                else if (rep_hit) begin
                    pulse_next     = 1'b1;
                    dir_next       = d2;
                    hold_next      = '0;
                    repeating_next = 1'b1;
                end else begin
                    hold_next = hold + HW'(1);
                end
`endif
            end
            DEB_RELEASE: begin
                // Hold counter is deliberately left frozen here; it resumes on a return to PRESSED.
                if (s2) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt == CNT_DONE) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        level_next = (state_next == PRESSED) || (state_next == DEB_RELEASE);
    end

endmodule

// File: tb/tb_ece453_button_conditioner.sv
// Directed bench for ece453_button_conditioner: vector table plus hand-written corner sequences.
// Build with +define+ECE453_BTN_REPEAT_EN to check the repeat variant.
module tb_ece453_button_conditioner;

    localparam int DEB = 4;
    localparam int RDL = 16;
    localparam int RPR = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       button_raw = 1'b0;
    logic       dir_raw = 1'b0;
    logic       button_pulse, direction, button_level;
    logic [7:0] press_count;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       rst_n;
        logic       b;
        logic       d;
        logic       exp_pulse;
        logic       exp_dir;
        logic       exp_level;
        logic [7:0] exp_count;
    } vec_t;

    vec_t vecs[$];

    ece453_button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RDL),
        .REPEAT_PERIOD  (RPR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .button_raw  (button_raw),
        .dir_raw     (dir_raw),
        .button_pulse(button_pulse),
        .direction   (direction),
        .button_level(button_level),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, then sample 1 ns after the next rising edge.
    task automatic step(input logic r, input logic b, input logic d);
        @(negedge clk);
        reset      = r;
        button_raw = b;
        dir_raw    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic b, input logic d, input logic p,
                       input logic dr, input logic l, input logic [7:0] c);
        vec_t v;
        v.rst_n = r; v.b = b; v.d = d;
        v.exp_pulse = p; v.exp_dir = dr; v.exp_level = l; v.exp_count = c;
        vecs.push_back(v);
    endtask

    task automatic check_all(input string tag, input logic p, input logic dr,
                             input logic l, input logic [7:0] c);
        check({tag, ".pulse"}, 32'(button_pulse), 32'(p));
        check({tag, ".dir"},   32'(direction),    32'(dr));
        check({tag, ".level"}, 32'(button_level), 32'(l));
        check({tag, ".count"}, 32'(press_count),  32'(c));
    endtask

    initial begin
        // Reset 3 cycles, then idle with dir_raw toggling: direction must stay 0.
        for (int i = 0; i < 3; i++)  add(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) add(1, 0, (i % 2) == 1, 0, 0, 0, 0);
        // Clean press, dir=1: pulse after edge k+6, then held to 20 samples.
        for (int i = 0; i < 6; i++)  add(1, 1, 1, 0, 0, 0, 0);
        add(1, 1, 1, 1, 1, 1, 1);
        for (int i = 0; i < 13; i++) add(1, 1, 1, 0, 1, 1, 1);
        // Release: level falls after edge j+6.
        for (int i = 0; i < 6; i++)  add(1, 0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 4; i++)  add(1, 0, 0, 0, 1, 0, 1);
        // Press bounce 1,1,0,1,1 then low: rejected.
        add(1, 1, 0, 0, 1, 0, 1);
        add(1, 1, 0, 0, 1, 0, 1);
        add(1, 0, 0, 0, 1, 0, 1);
        add(1, 1, 0, 0, 1, 0, 1);
        add(1, 1, 0, 0, 1, 0, 1);
        for (int i = 0; i < 8; i++)  add(1, 0, 0, 0, 1, 0, 1);
        // Second press with dir=0, then release bounce 0,0,1 and a clean low.
        for (int i = 0; i < 6; i++)  add(1, 1, 0, 0, 1, 0, 1);
        add(1, 1, 0, 1, 0, 1, 2);
        for (int i = 0; i < 3; i++)  add(1, 1, 0, 0, 0, 1, 2);
        add(1, 0, 0, 0, 0, 1, 2);
        add(1, 0, 0, 0, 0, 1, 2);
        add(1, 1, 0, 0, 0, 1, 2);
        for (int i = 0; i < 6; i++)  add(1, 0, 0, 0, 0, 1, 2);
        for (int i = 0; i < 4; i++)  add(1, 0, 0, 0, 0, 0, 2);

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].b, vecs[i].d);
            check_all($sformatf("vec%0d", i), vecs[i].exp_pulse, vecs[i].exp_dir,
                      vecs[i].exp_level, vecs[i].exp_count);
        end

        // Reset lands mid-debounce: no pulse, counters cleared, fresh press afterwards.
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 1);
            check($sformatf("midrst.pre%0d.pulse", i), 32'(button_pulse), 32'd0);
        end
        step(0, 1, 1);
        check_all("midrst.reset", 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 1);
            check($sformatf("midrst.post%0d.pulse", i), 32'(button_pulse), 32'd0);
        end
        step(1, 1, 1);
        check_all("midrst.pulse", 1, 1, 1, 1);
        step(1, 1, 1);
        check("midrst.after.pulse", 32'(button_pulse), 32'd0);
        for (int i = 0; i < 10; i++) step(1, 0, 0);
        check_all("midrst.released", 0, 1, 0, 1);

        // Long hold with dir_raw toggled 20 cycles after the initial pulse.
        for (int i = 0; i < 6; i++) step(1, 1, 0);
        step(1, 1, 0);
        check_all("hold.first", 1, 0, 1, 2);
        for (int t = 1; t <= 44; t++) begin
            logic ep, ed;
            step(1, 1, (t >= 20));
`ifdef ECE453_BTN_REPEAT_EN
            ep = (t == 16) || (t == 24) || (t == 32) || (t == 40);
            ed = (t >= 24);
`else
            ep = 1'b0;
            ed = 1'b0;
`endif
            check($sformatf("hold.t%0d.pulse", t), 32'(button_pulse), 32'(ep));
            check($sformatf("hold.t%0d.dir", t),   32'(direction),    32'(ed));
        end
        check("hold.count", 32'(press_count), 32'd2);
        for (int i = 0; i < 10; i++) step(1, 0, 0);
        check("hold.released.level", 32'(button_level), 32'd0);

        // press_count wrap: 253 more presses reach 255, one more wraps to 0.
        for (int n = 0; n < 254; n++) begin
            for (int i = 0; i < 8; i++) step(1, 1, 0);
            for (int i = 0; i < 8; i++) step(1, 0, 0);
            if (n == 252) check("wrap.255", 32'(press_count), 32'd255);
        end
        check("wrap.0", 32'(press_count), 32'd0);
        check("wrap.level", 32'(button_level), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Pulse must never last two consecutive cycles.
    logic prev_pulse = 1'b0;
    always @(posedge clk) begin
        #1;
        if (prev_pulse && button_pulse) begin
            n_bad++;
            $display("FAIL double_pulse @%0t: got 2 consecutive pulse cycles expected 1", $time);
        end
        prev_pulse = button_pulse;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
